// File: rtl/maxnet_controller.sv
// Sequencing FSM for the 4-neuron Maxnet datapath: load, wait out PU latency, write back, repeat until one winner.
// Optional iteration bound enabled by defining MAXNET_CTRL_TIMEOUT_EN.
module maxnet_controller #(
    parameter int PU_LATENCY = 2,
    parameter int MAX_ITER   = 63,
    parameter int ITER_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              is_finished_i,
    output logic              load_a_o,
    output logic              load_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_count_o,
    output logic              timeout_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] WAIT_INIT = 4'(PU_LATENCY);

    logic [2:0]        state_q, state_d;
    logic [ITER_W-1:0] iterCount_q, iterCount_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic              timeout_q, timeout_d;
    logic              timeoutHit;

`ifdef MAXNET_CTRL_TIMEOUT_EN
    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
    assign timeoutHit = (iterCount_q == MAX_ITER_C);
`else
    logic unusedMaxIter;
    assign unusedMaxIter = (MAX_ITER > 0);
    assign timeoutHit    = 1'b0;
`endif

    // Next-state logic; a finished datapath outranks the iteration bound in CHECK.
    always_comb begin
        state_d     = state_q;
        iterCount_d = iterCount_q;
        waitCnt_d   = waitCnt_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                iterCount_d = '0;
                timeout_d   = 1'b0;
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                if (is_finished_i) begin
                    state_d = S_DONE;
                end else if (timeoutHit) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    waitCnt_d = WAIT_INIT;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                waitCnt_d = waitCnt_q - 4'd1;
                if (waitCnt_q <= 4'd1) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (iterCount_q != '1) begin
                    iterCount_d = iterCount_q + 1'b1;
                end
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            iterCount_q <= '0;
            waitCnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iterCount_q <= iterCount_d;
            waitCnt_q   <= waitCnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Outputs decode from state or registers only, so no input reaches an output combinationally.
    assign load_a_o     = (state_q == S_LOAD) || (state_q == S_UPDATE);
    assign load_sel_o   = (state_q == S_LOAD);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign iter_count_o = iterCount_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller; a small datapath model raises is_finished after a set number of write-backs.
// Timeout scenario adapts to whether MAXNET_CTRL_TIMEOUT_EN is defined.
module tb_maxnet_controller;

    localparam int L      = 2;
    localparam int MAXI   = 4;
    localparam int ITERW  = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             isFinished;
    logic             loadA;
    logic             loadSel;
    logic             busy;
    logic             done;
    logic [ITERW-1:0] iterCount;
    logic             timeout;

    typedef struct {
        int   doneRel;
        int   iter;
        logic to;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   startCyc = 0;
    int   doneSeen = 0;
    int   updates = 0;
    int   needed = 0;

    maxnet_controller #(.PU_LATENCY(L), .MAX_ITER(MAXI), .ITER_W(ITERW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .is_finished_i(isFinished),
        .load_a_o(loadA),
        .load_sel_o(loadSel),
        .busy_o(busy),
        .done_o(done),
        .iter_count_o(iterCount),
        .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: counts PU write-backs since the last memory load.
    always @(posedge clk) begin
        if (rst) updates <= 0;
        else if (loadA && loadSel) updates <= 0;
        else if (loadA && !loadSel) updates <= updates + 1;
    end
    assign isFinished = (updates >= needed);

    // Scoreboard consumer: every done pulse must match the oldest expected run.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            doneSeen++;
            if (expQ.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpected_done: done at rel cycle %0d, required no done", cyc - startCyc);
            end else begin
                e = expQ.pop_front();
                total++;
                if ((cyc - startCyc) !== e.doneRel) begin
                    bad++;
                    $display("[TB] FAIL done_cycle: got %0d, required %0d", cyc - startCyc, e.doneRel);
                end
                total++;
                if (int'(iterCount) !== e.iter) begin
                    bad++;
                    $display("[TB] FAIL done_iter: got %0d, required %0d", iterCount, e.iter);
                end
                total++;
                if (timeout !== e.to) begin
                    bad++;
                    $display("[TB] FAIL done_timeout: got %0b, required %0b", timeout, e.to);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({loadA, loadSel, busy, done, timeout} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b, required 00000", {loadA, loadSel, busy, done, timeout});
        end
        total++;
        if (iterCount !== '0) begin
            bad++;
            $display("[TB] FAIL reset_iter: got %0d, required 0", iterCount);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({busy, loadA} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL idle_quiet: busy/load_a got %b, required 00", {busy, loadA});
            end
        end
    endtask

    task automatic test_immediate();
        needed = 0;
        @(negedge clk);
        start = 1'b1;
        startCyc = cyc;
        expQ.push_back('{doneRel: 3, iter: 0, to: 1'b0});
        for (int r = 1; r <= 5; r++) begin
            @(negedge clk);
            start = 1'b0;
            if (r == 1) begin
                total++;
                if ({loadA, loadSel, busy} !== 3'b111) begin
                    bad++;
                    $display("[TB] FAIL imm_load: load_a/load_sel/busy got %b, required 111", {loadA, loadSel, busy});
                end
            end
            if (r == 4) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL imm_busy_fall: got %b, required 0", busy);
                end
            end
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL imm_drain: %0d runs pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_convergence();
        logic expA, expS, expB;
        needed = 3;
        @(negedge clk);
        start = 1'b1;
        startCyc = cyc;
        expQ.push_back('{doneRel: 15, iter: 3, to: 1'b0});
        for (int r = 1; r <= 18; r++) begin
            @(negedge clk);
            start = 1'b0;
            expA = (r == 1) || (r == 5) || (r == 9) || (r == 13);
            expS = (r == 1);
            expB = (r <= 15);
            total++;
            if ({loadA, loadSel, busy} !== {expA, expS, expB}) begin
                bad++;
                $display("[TB] FAIL conv_trace: rel %0d load_a/load_sel/busy got %b, required %b", r, {loadA, loadSel, busy}, {expA, expS, expB});
            end
        end
        total++;
        if (iterCount !== 8'd3) begin
            bad++;
            $display("[TB] FAIL conv_iter_hold: got %0d, required 3", iterCount);
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL conv_drain: %0d runs pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_timeout();
        int seenBefore;
        needed = 1000;
        seenBefore = doneSeen;
        @(negedge clk);
        start = 1'b1;
        startCyc = cyc;
`ifdef MAXNET_CTRL_TIMEOUT_EN
        expQ.push_back('{doneRel: 19, iter: MAXI, to: 1'b1});
        for (int r = 1; r <= 21; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ({timeout, iterCount} !== {1'b1, 8'(MAXI)}) begin
            bad++;
            $display("[TB] FAIL to_hold: timeout/iter got %b/%0d, required 1/%0d", timeout, iterCount, MAXI);
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL to_drain: %0d runs pending, required 0", expQ.size());
            expQ.delete();
        end
`else
        for (int r = 1; r <= 200; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ((doneSeen - seenBefore) !== 0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL no_timeout: dones %0d busy %b, required 0 and 1", doneSeen - seenBefore, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        total++;
        if (timeout !== 1'b1 && timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL to_known: got %b, required known value", timeout);
        end
    endtask

    task automatic test_reset_midrun();
        needed = 3;
        @(negedge clk);
        start = 1'b1;
        startCyc = cyc;
        for (int r = 1; r <= 8; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (iterCount !== 8'd1) begin
            bad++;
            $display("[TB] FAIL mid_iter_before: got %0d, required 1", iterCount);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        total++;
        if ({busy, loadA, done, timeout} !== 4'b0 || iterCount !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset: busy/load_a/done/timeout got %b iter %0d, required 0000 iter 0", {busy, loadA, done, timeout}, iterCount);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_start_dropped: busy got %b, required 0", busy);
        end
        start = 1'b1;
        startCyc = cyc;
        expQ.push_back('{doneRel: 15, iter: 3, to: 1'b0});
        for (int r = 1; r <= 17; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL mid_rerun_drain: %0d runs pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_back_to_back();
        int seenBefore;
        needed = 1;
        seenBefore = doneSeen;
        @(negedge clk);
        start = 1'b1;
        startCyc = cyc;
        expQ.push_back('{doneRel: 7, iter: 1, to: 1'b0});
        for (int r = 1; r <= 14; r++) begin
            @(negedge clk);
            start = (r == 2) || (r == 3) || (r == 7);
            total++;
            if (busy !== (r <= 7)) begin
                bad++;
                $display("[TB] FAIL b2b_busy: rel %0d got %b, required %b", r, busy, (r <= 7));
            end
        end
        start = 1'b0;
        total++;
        if ((doneSeen - seenBefore) !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_done_count: got %0d, required 1", doneSeen - seenBefore);
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL b2b_drain: %0d runs pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_immediate();
        test_convergence();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing FSM for the 4-neuron Maxnet datapath. Loads initial activations from memory and waits out the PU pipeline latency on each iteration. It then commits PU outputs back into the neuron registers and stops once the datapath reports a single surviving neuron. It sits directly above the datapath, driving `load_a`/`load_sel` and consuming `is_finished`, and gives the system a start/done handshake plus an iteration count.

## Interface
- `PU_LATENCY`, default 2: clock cycles from neuron-register update to valid PU outputs; legal range 1..15.
- `MAX_ITER`, default 63: iteration bound; only used with `MAXNET_CTRL_TIMEOUT_EN`; legal range 1..255.
- `ITER_W`, default 8: width of `iter_count`.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new run; sampled only in IDLE.
- `is_finished`, input, 1: datapath flag, high when exactly one neuron register is nonzero.
- `load_a`, output, 1: load enable for all four neuron registers.
- `load_sel`, output, 1: register source select; 1 selects the memory X values, 0 selects the PU outputs.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse; the datapath `res` is valid in that cycle.
- `iter_count`, output, `ITER_W`: number of PU write-back iterations in the current or last run.
- `timeout`, output, 1: valid with `done`; high when the run ended on `MAX_ITER` rather than on `is_finished`.

## Operation
- States and actions:
  - IDLE: `start`=1 moves to LOAD.
  - LOAD: one cycle; `load_a`=1, `load_sel`=1; clears `iter_count`; moves to CHECK.
  - CHECK: one cycle; samples `is_finished`, which reflects the registers written on the previous edge.
    - Finished: go to DONE.
    - Else, timeout reached: go to DONE with `timeout` set.
    - Else: go to WAIT.
  - WAIT: holds for `PU_LATENCY` cycles using an internal down-counter loaded on entry; then moves to UPDATE.
  - UPDATE: one cycle; `load_a`=1, `load_sel`=0; `iter_count`+1 (saturating at all-ones); moves to CHECK.
  - DONE: one cycle; `done`=1; returns to IDLE.
- Timeout condition: `iter_count` == `MAX_ITER` (only with `MAXNET_CTRL_TIMEOUT_EN`).
- `load_sel` is 0 in every state except LOAD. `load_a` is high only in LOAD and UPDATE.
- `timeout` and `iter_count` hold their final values after DONE until the next LOAD.
- `start` outside IDLE is ignored, including in the DONE cycle. There is no queuing.
- An input already having a single winner finishes with `iter_count`=0 and no UPDATE cycle.

## Timing
- Reset values: state IDLE, `load_a`=0, `load_sel`=0, `busy`=0, `done`=0, `iter_count`=0, `timeout`=0, WAIT counter=0.
- All outputs are registered or decoded directly from state. There is no combinational path from `start` or `is_finished` to any output.
- Cycle count: `start` high in IDLE at cycle 0 gives LOAD at cycle 1 and CHECK at cycle 2.
- Each iteration costs `PU_LATENCY`+2 cycles: WAIT, UPDATE, CHECK.
- `done` is high in cycle 3 + N·(`PU_LATENCY`+2) for N iterations.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `rst` in any state returns to IDLE on the next edge with all outputs at reset values. The datapath shares `rst`, so a partial run leaves no residue.
- `rst` and `start` high together: `rst` wins and `start` is dropped.

## Configuration
- `MAXNET_CTRL_TIMEOUT_EN` defined:
  - CHECK also exits to DONE when `iter_count` == `MAX_ITER`, with `timeout`=1.
  - The `is_finished` check takes priority when both conditions hold in the same CHECK; `timeout` is then 0.
- Not defined:
  - The controller iterates until `is_finished` only.
  - `timeout` is tied to 0.
  - `MAX_ITER` is ignored.

## Test plan
- Reset: assert `rst` for 2 cycles -> all outputs 0; hold `start`=0 for 10 cycles -> `busy` stays 0 and `load_a` stays 0.
- Immediate winner: X={0,0,5,0}, pulse `start` at cycle 0 -> `load_a`/`load_sel`=1 in cycle 1, `done` in cycle 3, `iter_count`=0, `timeout`=0.
- Convergence: `PU_LATENCY`=2, X={0.2,0.4,0.6,0.8} needing 3 iterations -> `load_a` with `load_sel`=0 in cycles 5, 9, 13; `done` in cycle 15; `iter_count`=3.
- Timeout (macro on, `MAX_ITER`=4): X={1,1,1,1} (never singles out) -> `done` in cycle 19 with `timeout`=1 and `iter_count`=4. With the macro off, no `done` within 200 cycles.
- Reset mid-run: `rst` asserted in the second WAIT cycle -> IDLE next edge, `busy`=0, `iter_count`=0. A new `start` gives a full nominal run.
- Busy `start`: `start` pulsed in CHECK, WAIT and DONE -> ignored; exactly one `done` per accepted start.
